dmem_request_unit: RTL

Parametrised data-memory request unit for the multicycle/cached datapath, between the control unit outputs and the cache/memory-controller request ports. It latches a load/store at the instruction hit, holds the request until the data hit, and gates the PC. It extends the basic request path with LL/SC link tracking plus snoop invalidation, sticky halt capture and a saturating stall counter.

---
 rtl/dmem_request_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dmem_request_unit.sv
// Data-memory request unit: latches load/store at ihit, holds it to dhit,
// gates the PC, tracks the LL/SC link, captures halt and counts data stalls.
module dmem_request_unit #(
  parameter int WORD_W  = 32,
  parameter int CNT_W   = 16,
  parameter int LINK_EN = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              cu_dREN,
  input  logic              cu_dWEN,
  input  logic              cu_datomic,
  input  logic              cu_halt,
  input  logic [WORD_W-1:0] cu_addr,
  input  logic [WORD_W-1:0] cu_store,
  input  logic              inv_valid,
  input  logic [WORD_W-1:0] inv_addr,
  output logic              dREN,
  output logic              dWEN,
  output logic              datomic,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              pc_en,
  output logic              sc_success,
  output logic              halt,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {
    IDLE,
    DREQ,
    HALTED
  } state_t;

  state_t state, state_n;

  logic              link_valid, link_valid_n;
  logic [WORD_W-1:0] link_addr, link_addr_n;
  logic              is_mem, sc_fail, accept, done;
  logic              link_set, store_hit, inv_hit;

  function automatic logic word_match(
    input logic [WORD_W-1:0] a,
    input logic [WORD_W-1:0] b
  );
    return ((a ^ b) >> 2) == '0;
  endfunction

  assign is_mem  = cu_dREN | cu_dWEN;
  assign sc_fail = (LINK_EN != 0) & cu_dWEN & cu_datomic
                 & ~(link_valid & word_match(cu_addr, link_addr));

  always_comb begin
    state_n    = state;
    pc_en      = 1'b0;
    sc_success = 1'b0;
    accept     = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (ihit) begin
          if (cu_halt) begin
            state_n = HALTED;
          end else if (!is_mem || sc_fail) begin
            pc_en = 1'b1;
          end else begin
            accept  = 1'b1;
            state_n = DREQ;
          end
        end
      end
      DREQ: begin
        sc_success = dWEN & datomic;
        if (dhit) begin
          pc_en   = 1'b1;
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      HALTED: state_n = HALTED;
      default: state_n = IDLE;
    endcase
  end

  // Invalidate is checked against the post-LL address so it wins a collision.
  assign link_set    = (LINK_EN != 0) & done & dREN & datomic;
  assign link_addr_n = link_set ? dmemaddr : link_addr;
  assign store_hit   = done & dWEN & word_match(dmemaddr, link_addr);
  assign inv_hit     = inv_valid & word_match(inv_addr, link_addr_n);

  always_comb begin
    link_valid_n = link_valid;
    if (link_set)
      link_valid_n = 1'b1;
    if (store_hit || inv_hit)
      link_valid_n = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      dREN        <= 1'b0;
      dWEN        <= 1'b0;
      datomic     <= 1'b0;
      dmemaddr    <= '0;
      dmemstore   <= '0;
      halt        <= 1'b0;
      link_valid  <= 1'b0;
      link_addr   <= '0;
      stall_count <= '0;
    end else begin
      state      <= state_n;
      link_valid <= link_valid_n;
      link_addr  <= link_addr_n;
      if (state_n == HALTED)
        halt <= 1'b1;
      if (accept) begin
        dREN      <= cu_dREN;
        dWEN      <= cu_dWEN;
        datomic   <= cu_datomic;
        dmemaddr  <= cu_addr;
        dmemstore <= cu_store;
      end else if (done) begin
        dREN    <= 1'b0;
        dWEN    <= 1'b0;
        datomic <= 1'b0;
      end
      if (state == DREQ && !dhit && !(&stall_count))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule
